fixed_div_seq: RTL and testbench

- Multi-cycle sign-magnitude Q16.16 reciprocal/divide engine.
- Runs Newton-Raphson, x ← x·(2 − |b|·x), on one shared multiplier and one shared adder, sequenced by an FSM.
- Replaces the fully unrolled combinational reciprocal/divide chain wherever area matters more than latency. Neuron update logic (conductance/exp normalisation) uses it through a valid/ready handshake.

---
 rtl/fixed_pkg.sv | 37 +++
 rtl/fixed_div_seq_if.sv | 26 ++
 rtl/fixed_seed_gen.sv | 39 +++
 rtl/fixed_div_seq.sv | 172 +++++++++++++++++
 tb/tb_fixed_div_seq.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared types, constants and helpers for the sequential sign-magnitude Q16.16 divider.
package fixed_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned Q  = 16;
    localparam int unsigned MW = N - 1;

    localparam logic [N-1:0] FX_ONE     = 32'h0001_0000;
    localparam logic [N-1:0] FX_TWO     = 32'h0002_0000;
    localparam logic [N-1:0] FX_MAG_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_MUL_AX,
        S_SUB,
        S_MUL_X,
        S_FINAL,
        S_DONE
    } div_state_t;

    // Pack sign and magnitude, never producing a negative zero
    function automatic logic [N-1:0] sm_sign_fix(input logic sign, input logic [MW-1:0] mag);
        return {sign & (|mag), mag};
    endfunction

    // Rescale a full magnitude product back to Q16.16, saturating on overflow
    function automatic logic [MW-1:0] mul_q_sat(input logic [2*MW-1:0] prod);
        logic [2*MW-1:0] shifted;
        shifted = prod >> Q;
        if (|shifted[2*MW-1:MW]) begin
            return FX_MAG_MAX[MW-1:0];
        end
        return shifted[MW-1:0];
    endfunction

endpackage

// File: rtl/fixed_div_seq_if.sv
// Request/response handshake bundle between a client and the divider.
interface fixed_div_seq_if
    import fixed_pkg::*;
();

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );

endinterface

// File: rtl/fixed_seed_gen.sv
// Newton-Raphson seed: power-of-two estimate of 1/|b| from the leading one of |b|.
module fixed_seed_gen
    import fixed_pkg::*;
(
    input  logic [MW-1:0] b_mag,
    output logic [MW-1:0] x0_c,
    output logic          zero_c
);

    localparam int unsigned LW = $clog2(MW);

    logic [LW-1:0] lead;
    int            shift_amt;

    // Leading-one position of the divisor magnitude
    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(MW); i++) begin
            if (b_mag[i]) begin
                lead = LW'(i);
            end
        end
    end

    // x0 = 2^(2Q-1-p) keeps |b|*x0 in [0.5, 1); saturate when it does not fit
    always_comb begin
        zero_c    = (b_mag == '0);
        shift_amt = int'(2 * Q - 1) - int'(lead);
        x0_c      = '0;
        if (!zero_c) begin
            if (shift_amt > int'(MW - 1)) begin
                x0_c = FX_MAG_MAX[MW-1:0];
            end else begin
                x0_c = MW'(1) << shift_amt;
            end
        end
    end

endmodule

// File: rtl/fixed_div_seq.sv
// Multi-cycle Q16.16 reciprocal/divide: Newton-Raphson on one shared multiplier and adder.
module fixed_div_seq
    import fixed_pkg::*;
#(
    parameter int unsigned ITERS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    fixed_div_seq_if.slave bus
);

    localparam int unsigned CW = $clog2(ITERS + 1);
    localparam int unsigned PW = 2 * MW;

    div_state_t    state_q, state_d;
    logic [MW-1:0] a_mag_q, a_mag_d;
    logic [MW-1:0] b_mag_q, b_mag_d;
    logic [MW-1:0] x_q, x_d;
    logic [MW-1:0] t_q, t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic          sign_q, sign_d;
    logic [N-1:0]  result_q, result_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [MW-1:0] seed_x0;
    logic          seed_zero;
    logic [MW-1:0] mul_b;
    logic [PW-1:0] prod;
    logic [MW-1:0] mul_res;
    logic [MW-1:0] sub_res;
    logic [CW-1:0] cnt_inc;

    fixed_seed_gen u_seed (
        .b_mag  (b_mag_q),
        .x0_c   (seed_x0),
        .zero_c (seed_zero)
    );

    // Shared multiplier: x times |b|, the correction term, or |a| depending on phase
    always_comb begin
        mul_b = b_mag_q;
        if (state_q == S_MUL_X) begin
            mul_b = t_q;
        end else if (state_q == S_FINAL) begin
            mul_b = a_mag_q;
        end
        prod    = PW'(x_q) * PW'(mul_b);
        mul_res = mul_q_sat(prod);
    end

    // Shared adder: 2 - |b|x, clamped to zero once the product reaches 2.0
    always_comb begin
        sub_res = (t_q >= FX_TWO[MW-1:0]) ? '0 : (FX_TWO[MW-1:0] - t_q);
        cnt_inc = cnt_q + CW'(1);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        x_d         = x_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sign_d      = sign_q;
        result_d    = result_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_mag_d = bus.a[MW-1:0];
                    b_mag_d = bus.b[MW-1:0];
                    op_d    = bus.op;
                    sign_d  = bus.op ? (bus.a[N-1] ^ bus.b[N-1]) : bus.b[N-1];
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                if (seed_zero) begin
                    result_d    = sm_sign_fix(sign_q, FX_MAG_MAX[MW-1:0]);
                    dbz_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    x_d     = seed_x0;
                    cnt_d   = '0;
                    state_d = S_MUL_AX;
                end
            end
            S_MUL_AX: begin
                t_d     = mul_res;
                state_d = S_SUB;
            end
            S_SUB: begin
                t_d     = sub_res;
                state_d = S_MUL_X;
            end
            S_MUL_X: begin
                x_d   = mul_res;
                cnt_d = cnt_inc;
                if (cnt_inc < CW'(ITERS)) begin
                    state_d = S_MUL_AX;
                end else if (op_q) begin
                    state_d = S_FINAL;
                end else begin
                    result_d    = sm_sign_fix(sign_q, mul_res);
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_FINAL: begin
                result_d    = sm_sign_fix(sign_q, mul_res);
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            x_q         <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            x_q         <= x_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Bench for fixed_div_seq: ideal-division reference model, scoreboard queue, per-scenario checks.
module tb_fixed_div_seq;
    import fixed_pkg::*;

    localparam int unsigned ITERS     = 5;
    localparam int          LAT_RECIP = 1 + 3 * ITERS;
    localparam int          LAT_DIV   = 2 + 3 * ITERS;
    localparam int          LAT_DBZ   = 1;
    localparam longint      TOL       = 2;

    typedef struct {
        logic [N-1:0] res;
        logic         dbz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc   = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    exp_t   sb_q[$];

    fixed_div_seq_if bus ();

    fixed_div_seq #(.ITERS(ITERS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal result: exact quotient truncated, saturated, sign rules applied
    function automatic exp_t model(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t          e;
        logic [63:0]   num;
        logic [63:0]   quo;
        logic [MW-1:0] mag;
        logic          sign;
        sign = op ? (a[N-1] ^ b[N-1]) : b[N-1];
        if (b[MW-1:0] == '0) begin
            mag   = '1;
            e.dbz = 1'b1;
            e.lat = LAT_DBZ;
        end else begin
            num   = op ? (64'(a[MW-1:0]) << Q) : (64'(FX_ONE) << Q);
            quo   = num / 64'(b[MW-1:0]);
            mag   = (quo > 64'(FX_MAG_MAX)) ? '1 : quo[MW-1:0];
            e.dbz = 1'b0;
            e.lat = op ? LAT_DIV : LAT_RECIP;
        end
        e.res     = {sign & (|mag), mag};
        e.acc_cyc = 0;
        return e;
    endfunction

    // Present one request, wait (bounded) for acceptance, record the expectation
    task automatic send(input logic op, input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
        exp_t e;
        int   guard = 0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = bus.in_ready;
        if (ok) begin
            @(posedge clk); #1;
            e         = model(op, a, b);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int at_cyc, output bit ok);
        int guard = 0;
        while (!bus.out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        ok     = bus.out_valid;
        at_cyc = cyc;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;
        #22;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.result !== 32'h0) $display("FAIL reset result: got %h want 00000000", bus.result); else n_pass++;
        n_checks++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset dbz: got %b want 0", bus.div_by_zero); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reciprocal();
        logic [N-1:0] bs [4];
        bs = '{32'h0002_0000, 32'h0001_0000, 32'h8001_0000, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            exp_t   e;
            int     at;
            bit     ok;
            longint d;
            send(1'b0, 32'h1234_5678, bs[i], ok);
            if (ok) wait_out(at, ok);
            if (!ok || sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL recip[%0d] handshake: timed out", i);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                d = longint'(bus.result[MW-1:0]) - longint'(e.res[MW-1:0]);
                n_checks++; if (at - e.acc_cyc !== e.lat) $display("FAIL recip[%0d] latency: got %0d want %0d", i, at - e.acc_cyc, e.lat); else n_pass++;
                n_checks++; if (bus.result[N-1] !== e.res[N-1] || d > TOL || d < -TOL) $display("FAIL recip[%0d] result: got %h want %h +/-2", i, bus.result, e.res); else n_pass++;
                n_checks++; if (bus.div_by_zero !== e.dbz) $display("FAIL recip[%0d] dbz: got %b want %b", i, bus.div_by_zero, e.dbz); else n_pass++;
            end
            release_out();
        end
    endtask

    task automatic test_divide();
        logic [N-1:0] as [5];
        logic [N-1:0] bs [5];
        as = '{32'h8003_0000, 32'h0001_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_0000};
        bs = '{32'h0001_8000, 32'h0001_0000, 32'h0001_0000, 32'h8002_0000, 32'h0000_8000};
        for (int i = 0; i < 5; i++) begin
            exp_t   e;
            int     at;
            bit     ok;
            longint d;
            send(1'b1, as[i], bs[i], ok);
            if (ok) wait_out(at, ok);
            if (!ok || sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL div[%0d] handshake: timed out", i);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                d = longint'(bus.result[MW-1:0]) - longint'(e.res[MW-1:0]);
                n_checks++; if (at - e.acc_cyc !== e.lat) $display("FAIL div[%0d] latency: got %0d want %0d", i, at - e.acc_cyc, e.lat); else n_pass++;
                n_checks++; if (bus.result[N-1] !== e.res[N-1] || d > TOL || d < -TOL) $display("FAIL div[%0d] result: got %h want %h +/-2", i, bus.result, e.res); else n_pass++;
                n_checks++; if (bus.div_by_zero !== e.dbz) $display("FAIL div[%0d] dbz: got %b want %b", i, bus.div_by_zero, e.dbz); else n_pass++;
            end
            release_out();
        end
    endtask

    task automatic test_zero_divisor();
        logic         ops [3];
        logic [N-1:0] as  [3];
        logic [N-1:0] bs  [3];
        ops = '{1'b0, 1'b1, 1'b0};
        as  = '{32'h0000_0000, 32'h8001_0000, 32'h0003_0000};
        bs  = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            int   at;
            bit   ok;
            send(ops[i], as[i], bs[i], ok);
            if (ok) wait_out(at, ok);
            if (!ok || sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL dbz[%0d] handshake: timed out", i);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                n_checks++; if (at - e.acc_cyc !== e.lat) $display("FAIL dbz[%0d] latency: got %0d want %0d", i, at - e.acc_cyc, e.lat); else n_pass++;
                n_checks++; if (bus.result !== e.res) $display("FAIL dbz[%0d] result: got %h want %h", i, bus.result, e.res); else n_pass++;
                n_checks++; if (bus.div_by_zero !== e.dbz) $display("FAIL dbz[%0d] flag: got %b want %b", i, bus.div_by_zero, e.dbz); else n_pass++;
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        exp_t         e;
        int           at;
        bit           ok;
        longint       d;
        logic [N-1:0] snap;
        send(1'b0, 32'h0, 32'h0002_0000, ok);
        if (ok) wait_out(at, ok);
        if (!ok || sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL bp handshake: timed out");
            sb_q.delete();
        end else begin
            e    = sb_q.pop_front();
            snap = bus.result;
            d    = longint'(bus.result[MW-1:0]) - longint'(e.res[MW-1:0]);
            n_checks++; if (bus.result[N-1] !== e.res[N-1] || d > TOL || d < -TOL) $display("FAIL bp result: got %h want %h +/-2", bus.result, e.res); else n_pass++;
            bus.in_valid = 1'b1;
            bus.op       = 1'b1;
            bus.a        = 32'h0005_0000;
            bus.b        = 32'h0001_0000;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== snap) $display("FAIL bp hold[%0d]: got valid=%b result=%h want valid=1 result=%h", i, bus.out_valid, bus.result, snap); else n_pass++;
                n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp in_ready[%0d]: got %b want 0", i, bus.in_ready); else n_pass++;
            end
            bus.in_valid = 1'b0;
            release_out();
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp release in_ready: got %b want 1", bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b0 || bus.result !== snap) $display("FAIL bp release out: got valid=%b result=%h want valid=0 result=%h", bus.out_valid, bus.result, snap); else n_pass++;
            repeat (3) @(posedge clk);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL bp not latched: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t   e;
        int     at;
        bit     ok;
        longint d;
        send(1'b0, 32'h0, 32'h0002_0000, ok);
        sb_q.delete();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.result !== 32'h0) $display("FAIL rst_mid result: got %h want 00000000", bus.result); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid in_ready: got %b want 1", bus.in_ready); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 32'h0, 32'h0004_0000, ok);
        if (ok) wait_out(at, ok);
        if (!ok || sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL rst_mid next handshake: timed out");
            sb_q.delete();
        end else begin
            e = sb_q.pop_front();
            d = longint'(bus.result[MW-1:0]) - longint'(e.res[MW-1:0]);
            n_checks++; if (at - e.acc_cyc !== e.lat) $display("FAIL rst_mid next latency: got %0d want %0d", at - e.acc_cyc, e.lat); else n_pass++;
            n_checks++; if (bus.result[N-1] !== e.res[N-1] || d > TOL || d < -TOL) $display("FAIL rst_mid next result: got %h want %h +/-2", bus.result, e.res); else n_pass++;
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic         ops [4];
        logic [N-1:0] as  [4];
        logic [N-1:0] bs  [4];
        ops = '{1'b0, 1'b1, 1'b0, 1'b1};
        as  = '{32'h0000_0000, 32'h0006_0000, 32'h0000_0000, 32'h0002_0000};
        bs  = '{32'h0004_0000, 32'h8003_0000, 32'h8000_8000, 32'h0000_0000};
        bus.out_ready = 1'b1;
        fork
            begin
                int prev_acc = 0;
                int prev_lat = 0;
                for (int i = 0; i < 4; i++) begin
                    bit ok;
                    send(ops[i], as[i], bs[i], ok);
                    if (!ok) begin
                        n_checks++;
                        $display("FAIL b2b send[%0d]: timed out", i);
                    end else if (i > 0) begin
                        n_checks++; if (cyc - prev_acc !== prev_lat + 2) $display("FAIL b2b interval[%0d]: got %0d want %0d", i, cyc - prev_acc, prev_lat + 2); else n_pass++;
                    end
                    prev_acc = cyc;
                    prev_lat = model(ops[i], as[i], bs[i]).lat;
                end
            end
            begin
                int got   = 0;
                int guard = 0;
                while (got < 4 && guard < 400) begin
                    @(posedge clk); #1;
                    guard++;
                    if (bus.out_valid) begin
                        exp_t   e;
                        longint d;
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL b2b out[%0d]: unexpected output %h", got, bus.result);
                        end else begin
                            e = sb_q.pop_front();
                            d = longint'(bus.result[MW-1:0]) - longint'(e.res[MW-1:0]);
                            n_checks++; if (cyc - e.acc_cyc !== e.lat) $display("FAIL b2b latency[%0d]: got %0d want %0d", got, cyc - e.acc_cyc, e.lat); else n_pass++;
                            n_checks++; if (bus.result[N-1] !== e.res[N-1] || d > TOL || d < -TOL || bus.div_by_zero !== e.dbz) $display("FAIL b2b result[%0d]: got %h dbz=%b want %h dbz=%b", got, bus.result, bus.div_by_zero, e.res, e.dbz); else n_pass++;
                        end
                        got++;
                    end
                end
                if (got < 4) begin
                    n_checks++;
                    $display("FAIL b2b outputs: got %0d want 4", got);
                end
            end
        join
        bus.out_ready = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_reciprocal();
        test_divide();
        test_zero_divisor();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
